// File: rtl/buzzer_tone_gen.sv
// Piezo square-wave generator: prescaler plus reloadable divider.
// Define BUZZER_TONE_SYNC_UPDATE_EN to defer pitch changes to wraps.
module buzzer_tone_gen #(
  parameter int PRESCALE  = 16,
  parameter int CNT_WIDTH = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] origin,
  output logic        speaker,
  output logic        half_done,
  output logic        muted
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(PRESCALE - 1);
  localparam logic [CNT_WIDTH-1:0] TOP = '1;
  localparam logic [15:0] MUTE_CODE = 16'(TOP);

  logic [PW-1:0]        presc;
  logic [PW-1:0]        presc_n;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic [CNT_WIDTH-1:0] div_cnt;
  logic [15:0]          org_eff;
  logic [15:0]          org_n;
  logic                 spk_n;
  logic                 hd_n;
  logic                 muted_n;
  logic                 div_spk;
  logic                 div_hd;
  logic                 tick;
  logic                 at_top;
  logic                 org_mute;

  function automatic logic is_mute(
    input logic [15:0] v
  );
    is_mute = (v[15:CNT_WIDTH] != '0) ||
              (v[CNT_WIDTH-1:0] == TOP);
  endfunction

  assign tick     = en & (presc == PMAX);
  assign at_top   = (cnt == TOP);
  assign org_mute = is_mute(org_eff);

  // One divider step, applied only on a tick
  always_comb begin
    div_cnt = cnt + 1'b1;
    div_spk = speaker;
    div_hd  = 1'b0;
    if (org_mute) begin
      div_cnt = TOP;
      div_spk = 1'b0;
    end else if (at_top) begin
      div_cnt = org_eff[CNT_WIDTH-1:0];
      div_spk = ~speaker;
      div_hd  = 1'b1;
    end
  end

`ifndef BUZZER_TONE_SYNC_UPDATE_EN
  logic new_mute;
  assign new_mute = is_mute(origin);
`endif

  always_comb begin
    presc_n = presc;
    cnt_n   = cnt;
    spk_n   = speaker;
    hd_n    = 1'b0;
    org_n   = org_eff;
    muted_n = org_mute | ~en;
    if (!en) begin
      presc_n = '0;
      cnt_n   = TOP;
      spk_n   = 1'b0;
      org_n   = origin;
    end else begin
      presc_n = tick ? '0 : presc + 1'b1;
`ifdef BUZZER_TONE_SYNC_UPDATE_EN
      if (tick) begin
        cnt_n = div_cnt;
        spk_n = div_spk;
        hd_n  = div_hd;
      end
      if ((tick & at_top) | org_mute)
        org_n = origin;
`else
      org_n = origin;
      if (origin != org_eff) begin
        // Leaving mute keeps cnt at TOP so the
        // next tick restarts the tone at once
        cnt_n = (new_mute | org_mute) ?
                TOP : origin[CNT_WIDTH-1:0];
        if (new_mute)
          spk_n = 1'b0;
      end else if (tick) begin
        cnt_n = div_cnt;
        spk_n = div_spk;
        hd_n  = div_hd;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      cnt       <= TOP;
      org_eff   <= MUTE_CODE;
      speaker   <= 1'b0;
      half_done <= 1'b0;
      muted     <= 1'b1;
    end else begin
      presc     <= presc_n;
      cnt       <= cnt_n;
      org_eff   <= org_n;
      speaker   <= spk_n;
      half_done <= hd_n;
      muted     <= muted_n;
    end
  end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen.
// Two instances: PRESCALE=1 and PRESCALE=3.
module tb_buzzer_tone_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en1 = 1'b0;
  logic        en3 = 1'b0;
  logic [15:0] org1 = 16'd16380;
  logic [15:0] org3 = 16'd16382;
  logic        spk1, hd1, mu1;
  logic        spk3, hd3, mu3;
  int          passed = 0;
  int          fails = 0;
  int          total = 0;

  always #5 clk = ~clk;

  buzzer_tone_gen #(
    .PRESCALE(1),
    .CNT_WIDTH(14)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .en(en1),
    .origin(org1),
    .speaker(spk1),
    .half_done(hd1),
    .muted(mu1)
  );

  buzzer_tone_gen #(
    .PRESCALE(3),
    .CNT_WIDTH(14)
  ) dut3 (
    .clk(clk),
    .rst(rst),
    .en(en3),
    .origin(org3),
    .speaker(spk3),
    .half_done(hd3),
    .muted(mu3)
  );

  task automatic chk(
    input string tag,
    input logic  obs,
    input logic  exp
  );
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic c1(
    input string t,
    input logic es,
    input logic eh,
    input logic em
  );
    chk({t, "/spk1"}, spk1, es);
    chk({t, "/hd1"}, hd1, eh);
    chk({t, "/mu1"}, mu1, em);
  endtask

  task automatic c3(
    input string t,
    input logic es,
    input logic eh,
    input logic em
  );
    chk({t, "/spk3"}, spk3, es);
    chk({t, "/hd3"}, hd3, eh);
    chk({t, "/mu3"}, mu3, em);
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    c1("rst", 0, 0, 1);
    c3("rst", 0, 0, 1);
    tk(2);
    rst = 1'b0;
    tk(2);
    c1("idle", 0, 0, 1);

    // steady tone, origin 16380: 4-clock levels
    en1 = 1'b1;
    tk(1);
    c1("e0", 1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      tk(1);
      c1($sformatf("steady%0d", k),
         ((k / 4) % 2) == 0, (k % 4) == 0, 1'b0);
    end

    // async reset mid-cycle while speaker high
    #3 rst = 1'b1;
    #1;
    c1("rst_async", 0, 0, 1);
    en1 = 1'b0;
    org1 = 16'd16383;
    tk(1);
    rst = 1'b0;
    tk(2);
    c1("rst_rel", 0, 0, 1);

    // mute codes
    en1 = 1'b1;
    tk(3);
    c1("mute_top", 0, 0, 1);
    org1 = 16'hC000;
    tk(3);
    c1("mute_c000", 0, 0, 1);
    org1 = 16'd16381;
    tk(1);
    c1("unmute_a", 0, 0, 1);
    tk(1);
    c1("unmute_b", 1, 1, 0);
    tk(1);
    c1("un1", 1, 0, 0);
    tk(1);
    c1("un2", 1, 0, 0);
    tk(1);
    c1("un3", 0, 1, 0);
    tk(3);
    c1("un6", 1, 1, 0);

    // mid-period change 16380 -> 16382
    en1 = 1'b0;
    org1 = 16'd16380;
    tk(1);
    c1("dis", 0, 0, 1);
    tk(1);
    en1 = 1'b1;
    tk(1);
    c1("w0", 1, 1, 0);
    org1 = 16'd16382;
    tk(1);
    c1("w1", 1, 0, 0);
    tk(1);
    c1("w2", 1, 0, 0);
`ifdef BUZZER_TONE_SYNC_UPDATE_EN
    tk(2);
    c1("w4", 0, 1, 0);
    tk(4);
    c1("w8", 1, 1, 0);
    tk(2);
    c1("w10", 0, 1, 0);
`else
    tk(1);
    c1("w3", 0, 1, 0);
    tk(2);
    c1("w5", 1, 1, 0);
    tk(2);
    c1("w7", 0, 1, 0);
`endif
    tk(2);
    c1("pre_drop", 1, 1, 0);

    // enable drop mid-level and re-enable
    en1 = 1'b0;
    tk(1);
    c1("drop", 0, 0, 1);
    tk(1);
    c1("drop2", 0, 0, 1);
    en1 = 1'b1;
    tk(1);
    c1("reen", 1, 1, 0);
    tk(1);
    c1("reen1", 1, 0, 0);
    tk(1);
    c1("reen2", 0, 1, 0);

    // prescaled: PRESCALE=3, 16382 -> 6 clocks
    en3 = 1'b1;
    tk(1);
    c3("p1", 0, 0, 0);
    tk(1);
    c3("p2", 0, 0, 0);
    tk(1);
    c3("p3", 1, 1, 0);
    tk(1);
    c3("p4", 1, 0, 0);
    tk(4);
    c3("p8", 1, 0, 0);
    tk(1);
    c3("p9", 0, 1, 0);
    tk(1);
    c3("p10", 0, 0, 0);
    tk(5);
    c3("p15", 1, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
